// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder signal bundle: raw encoder inputs in, counter step/direction/error out.
interface quad_step_decoder_if;
  logic a_in;
  logic b_in;
  logic en;
  logic dn;
  logic err;

  modport master (
    output a_in,
    output b_in,
    input  en,
    input  dn,
    input  err
  );

  modport slave (
    input  a_in,
    input  b_in,
    output en,
    output dn,
    output err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to counter en/dn: 2-FF sync, per-channel debounce, Gray-code step decode.
// Define QUAD_X4_EN for one step per quarter cycle; default is X1 (one step per full cycle).
module quad_step_decoder #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  quad_step_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P11 = 2'b11,
    P10 = 2'b10
  } pos_t;

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic [1:0] sync_v;
  logic [1:0] stable;
  logic [3:0] cnt [2];

  pos_t state;
  pos_t state_nxt;
  pos_t cur;

  logic step_up;
  logic step_dn;
  logic illegal;
  logic en_r;
  logic dn_r;
  logic err_r;
  logic en_nxt;
  logic dn_nxt;
  logic err_nxt;

`ifndef QUAD_X4_EN
  logic [1:0] q;
  logic [1:0] q_nxt;
`endif

  function automatic pos_t succ(input pos_t p);
    case (p)
      P00:     return P01;
      P01:     return P11;
      P11:     return P10;
      default: return P00;
    endcase
  endfunction

  function automatic pos_t pred(input pos_t p);
    case (p)
      P00:     return P10;
      P10:     return P11;
      P11:     return P01;
      default: return P00;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[0], bus.a_in};
      b_sync <= {b_sync[0], bus.b_in};
    end
  end

  // Bit 1 is channel A, bit 0 channel B, so the stable pair is directly the Gray position.
  assign sync_v = {a_sync[1], b_sync[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_v[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= sync_v[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  assign cur = pos_t'(stable);

  // State register also holds the registered outputs and the quarter accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= P00;
      en_r  <= 1'b0;
      dn_r  <= 1'b0;
      err_r <= 1'b0;
`ifndef QUAD_X4_EN
      q     <= '0;
`endif
    end else begin
      state <= state_nxt;
      en_r  <= en_nxt;
      dn_r  <= dn_nxt;
      err_r <= err_nxt;
`ifndef QUAD_X4_EN
      q     <= q_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = cur;
  end

  always_comb begin
    step_up = (cur != state) && (cur == succ(state));
    step_dn = (cur != state) && (cur == pred(state));
    illegal = (cur != state) && !step_up && !step_dn;
    en_nxt  = 1'b0;
    dn_nxt  = dn_r;
    err_nxt = illegal;
`ifdef QUAD_X4_EN
    if (step_up) begin
      en_nxt = 1'b1;
      dn_nxt = 1'b0;
    end else if (step_dn) begin
      en_nxt = 1'b1;
      dn_nxt = 1'b1;
    end
`else
    q_nxt = q;
    if (step_up) begin
      q_nxt = q + 2'd1;
      if (q == 2'd3) begin
        en_nxt = 1'b1;
        dn_nxt = 1'b0;
      end
    end else if (step_dn) begin
      q_nxt = q - 2'd1;
      if (q == 2'd0) begin
        en_nxt = 1'b1;
        dn_nxt = 1'b1;
      end
    end
`endif
  end

  assign bus.en  = en_r;
  assign bus.dn  = dn_r;
  assign bus.err = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder; expectations follow QUAD_X4_EN (X4) or its absence (X1).
module tb_quad_step_decoder;

  localparam int unsigned DEB = 4;
  localparam int LAT  = DEB + 3;
  localparam int HOLD = 20;

`ifdef QUAD_X4_EN
  localparam int   GL_EN   = 1;
  localparam logic BACK_DN = 1'b1;
  localparam int   RQ_EN   = 1;
`else
  localparam int   GL_EN   = 0;
  localparam logic BACK_DN = 1'b0;
  localparam int   RQ_EN   = 0;
`endif

  typedef struct {
    logic a;
    logic b;
    int   exp_en;
    logic exp_dn;
    int   exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  quad_step_decoder_if bus ();

  quad_step_decoder #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b);
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
  endtask

  task automatic observe(input int n, output int en_cnt, output int err_cnt,
                         output int first_en, output logic en_dn);
    en_cnt   = 0;
    err_cnt  = 0;
    first_en = -1;
    en_dn    = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (bus.en === 1'b1) begin
        en_cnt++;
        if (first_en < 0) begin
          first_en = k;
          en_dn    = bus.dn;
        end
      end
      if (bus.err === 1'b1) err_cnt++;
    end
  endtask

  initial begin
    int   en_cnt;
    int   err_cnt;
    int   first_en;
    logic en_dn;

`ifdef QUAD_X4_EN
    vecs.push_back('{1'b0, 1'b1, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 0});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 1, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b1, 0});
    vecs.push_back('{1'b1, 1'b1, 0, 1'b1, 1});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 0});
`else
    vecs.push_back('{1'b0, 1'b1, 0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b1, 0, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 1, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 0, 1'b1, 1});
    vecs.push_back('{1'b1, 1'b1, 1, 1'b0, 0});
    vecs.push_back('{1'b1, 1'b0, 0, 1'b0, 0});
    vecs.push_back('{1'b0, 1'b0, 0, 1'b0, 0});
`endif

    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    rst      = 1'b1;

    // Reset hold with toggling inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.a_in = 1'((i / 2) % 2);
      bus.b_in = ~1'((i / 2) % 2);
      #1;
      check("rst_hold", {29'd0, bus.en, bus.dn, bus.err}, 32'd0);
    end
    @(negedge clk);
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    rst      = 1'b0;
    observe(HOLD, en_cnt, err_cnt, first_en, en_dn);
    check("rel_en", en_cnt, 0);
    check("rel_err", err_cnt, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b);
      observe(HOLD, en_cnt, err_cnt, first_en, en_dn);
      check($sformatf("v%0d_en", i), en_cnt, vecs[i].exp_en);
      check($sformatf("v%0d_err", i), err_cnt, vecs[i].exp_err);
      if (en_cnt > 0) begin
        check($sformatf("v%0d_lat", i), first_en, LAT);
        check($sformatf("v%0d_endn", i), en_dn, vecs[i].exp_dn);
      end
      check($sformatf("v%0d_dnhold", i), bus.dn, vecs[i].exp_dn);
    end

    // Short glitch on B: three sampled cycles must be rejected
    drive(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    drive(1'b0, 1'b0);
    observe(HOLD, en_cnt, err_cnt, first_en, en_dn);
    check("glitch3_en", en_cnt, 0);
    check("glitch3_err", err_cnt, 0);

    drive(1'b0, 1'b1);
    observe(HOLD, en_cnt, err_cnt, first_en, en_dn);
    check("glitch4_en", en_cnt, GL_EN);
    check("glitch4_err", err_cnt, 0);
    if (en_cnt > 0) check("glitch4_lat", first_en, LAT);
    check("glitch4_dn", bus.dn, 0);

    drive(1'b0, 1'b0);
    observe(HOLD, en_cnt, err_cnt, first_en, en_dn);
    check("back_en", en_cnt, GL_EN);
    check("back_dn", bus.dn, BACK_DN);

    // Reset while A's filter count is in progress
    drive(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst", {29'd0, bus.en, bus.dn, bus.err}, 32'd0);
    bus.a_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    observe(30, en_cnt, err_cnt, first_en, en_dn);
    check("midrst_en", en_cnt, 0);
    check("midrst_err", err_cnt, 0);

    // Input already high at release is re-qualified from P=00
    @(negedge clk);
    rst      = 1'b1;
    bus.b_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    observe(30, en_cnt, err_cnt, first_en, en_dn);
    check("requal_en", en_cnt, RQ_EN);
    check("requal_err", err_cnt, 0);
    if (en_cnt > 0) check("requal_lat", first_en, LAT);
    check("requal_dn", bus.dn, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream feeder for the 4-bit up/down counter: converts raw quadrature encoder inputs (A/B) into the counter's `en` step pulse and `dn` direction level.
- Synchronises and debounces both channels, then decodes Gray-code transitions.
- Flags illegal double-bit transitions.
- Outputs connect directly to counter `en`/`dn` on the same clock.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronised input must differ from its stable value before the stable value updates. Legal range 1..15; internal filter counters are 4 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a_in  input  1  raw encoder channel A, asynchronous to clk.
- b_in  input  1  raw encoder channel B, asynchronous to clk.
- en  output  1  one-cycle step pulse, to counter `en`.
- dn  output  1  step direction, to counter `dn`. 0 = up, 1 = down. Held between steps.
- err  output  1  one-cycle pulse on an illegal transition.

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers clear: synchroniser FFs, filter counters, stable A/B, decoder state, quarter accumulator q.
  - en=0, dn=0, err=0; decoder state = 00.
- Synchroniser: 2-FF chain per channel. sa/sb = second-stage outputs.
- Debounce filter (per channel, independent):
  - When sync value == stable value: filter counter = 0.
  - When sync value != stable value: counter increments.
  - On the edge where the counter reaches DEB_CYCLES: stable value takes the sync value and the counter clears.
  - A mismatch shorter than DEB_CYCLES cycles never changes the stable value.
- Decoder: state P = {stable_a, stable_b}. Forward Gray sequence is 00→01→11→10→00.
  - Step into the forward successor: up step.
  - Step into the forward predecessor: down step.
  - Both stable bits change in the same cycle: err=1 for one cycle. P still updates, no step, dn unchanged.
  - No change: en=0, err=0.
- Output timing:
  - en, dn and err are registered.
  - en and err assert on the edge after the stable-value update.
  - The new dn is valid in the same cycle as en.
- Latency: en asserts after rising edge DEB_CYCLES+3, counting the first edge that samples the new input level as edge 1. It stays high exactly one cycle.
- Step spacing: each stable change produces at most one en. Back-to-back stable changes on consecutive cycles produce back-to-back en pulses.
- Reset mid-operation:
  - In-flight filter counts and pending pulses are discarded.
  - After release, inputs already high are re-qualified from P=00 and may yield one step or an err.

Optional Feature:
- Macro: QUAD_X4_EN.
- Defined (X4 mode): every legal quarter step emits en, with dn=0 for up and dn=1 for down.
- Undefined (X1 mode):
  - The 2-bit accumulator q increments on up steps and decrements on down steps.
  - en with dn=0 only when q wraps 3→0; en with dn=1 only when q wraps 0→3.
  - Other steps update q only.
  - err behaviour is identical in both modes; illegal transitions leave q unchanged.
- Bench is built in both configurations.

Test Plan:
- Reset hold: rst=1 for 10 cycles with a_in/b_in toggling every 2 cycles → en=dn=err=0 throughout. Release with a_in=b_in=0 → no pulse for 20 cycles.
- X4 forward (DEB_CYCLES=4):
  - Stimulus: drive {a,b} 00→01→11→10→00, each level held 20 cycles.
  - Expect: 4 en pulses, each 7 edges after its input change, dn=0, err=0.
  - The counter downstream goes 0→4.
- X4 reverse: from 00, drive 00→10→11→01→00 → 4 en pulses with dn=1 in the same cycle; counter 4→0.
- Glitch rejection:
  - b_in high for 3 cycles, then low → no en.
  - b_in high for 4 cycles, then held → exactly one en, dn=0.
- Illegal transition: from 00, drive a_in and b_in high on the same edge and hold → one err pulse, no en, dn keeps its previous value. Then drive 11→10 → normal up pulse.
- X1 mode (macro undefined):
  - 8 forward quarter steps → exactly 2 en pulses, dn=0, on the 4th and 8th steps.
  - Then 1 reverse step → one en with dn=1.
  - Then rst pulsed mid-step while a filter count is in progress → no en after release.
